// File: rtl/icache_pkg.sv
// Shared types and address-split width helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FILL
    } state_e;

    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int words, input int lines);
        return addr_w - 2 - $clog2(words) - $clog2(lines);
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data flop arrays: combinational read, one word written per cycle, bulk invalidate.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LINES  = 16,
    parameter int WORDS  = 4,
    parameter int TAG_W  = 24,
    localparam int IDX_W = idx_w(LINES),
    localparam int OFF_W = off_w(WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [OFF_W-1:0]  rd_off,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic              wr_last,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              inv_all
);

    logic [LINES-1:0]                         valid_q;
    logic [LINES-1:0][TAG_W-1:0]              tag_q;
    logic [LINES-1:0][WORDS-1:0][DATA_W-1:0]  data_q;

    // Invalidate beats a same-cycle line completion so a pending flush wins.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
        end else if (inv_all) begin
            valid_q <= '0;
        end else if (wr_en && wr_last) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            data_q[wr_idx][wr_off] <= wr_data;
            if (wr_last) begin
                tag_q[wr_idx] <= wr_tag;
            end
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx][rd_off];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, stall plus burst line refill on miss.
module icache
    import icache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = 16,
    parameter int WORDS  = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              flush_i,
    input  logic              inv_all_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ready_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int OFF_W = off_w(WORDS);
    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(ADDR_W, WORDS, LINES);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

    state_e            state_q, state_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic              inv_pend_q, inv_pend_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx, fill_idx;
    logic [TAG_W-1:0]  req_tag, fill_tag, rd_tag;
    logic              rd_valid, hit, idle;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en, wr_last, inv_clr;
    logic              unused_byte_bits;

    assign req_off  = addr_i[2 +: OFF_W];
    assign req_idx  = addr_i[2+OFF_W +: IDX_W];
    assign req_tag  = addr_i[ADDR_W-1 -: TAG_W];
    assign fill_idx = mem_addr_q[2+OFF_W +: IDX_W];
    assign fill_tag = mem_addr_q[ADDR_W-1 -: TAG_W];
    assign unused_byte_bits = ^addr_i[1:0];

    icache_line_store #(
        .DATA_W (DATA_W),
        .LINES  (LINES),
        .WORDS  (WORDS),
        .TAG_W  (TAG_W)
    ) u_store (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .rd_idx   (req_idx),
        .rd_off   (req_off),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_last  (wr_last),
        .wr_idx   (fill_idx),
        .wr_off   (cnt_q),
        .wr_data  (mem_rdata_i),
        .wr_tag   (fill_tag),
        .inv_all  (inv_clr)
    );

    // An invalidate seen in IDLE must already suppress this cycle's hit.
    assign idle       = (state_q == S_IDLE);
    assign hit        = rd_valid && (rd_tag == req_tag) && !(idle && inv_all_i);
    assign valid_o    = req_i && hit && idle;
    assign data_o     = valid_o ? rd_data : '0;
    assign stall_o    = !idle || (req_i && !hit);
    assign mem_req_o  = (state_q == S_REQ);
    assign mem_addr_o = mem_addr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            inv_pend_q <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inv_pend_q <= inv_pend_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        inv_pend_d = inv_pend_q;
        mem_addr_d = mem_addr_q;
        wr_en      = 1'b0;
        wr_last    = 1'b0;
        inv_clr    = 1'b0;
        case (state_q)
            S_IDLE: begin
                inv_clr = inv_all_i;
                if (req_i && !hit) begin
                    mem_addr_d = {req_tag, req_idx, {(OFF_W+2){1'b0}}};
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (mem_ready_i) begin
                    cnt_d   = '0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_rvalid_i) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        wr_last = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Invalidates raised mid-miss are deferred and applied on the edge back into IDLE.
        if (!idle) begin
            if (state_d == S_IDLE) begin
                inv_clr    = inv_pend_q || inv_all_i;
                inv_pend_d = 1'b0;
            end else if (inv_all_i) begin
                inv_pend_d = 1'b1;
            end
        end
    end

endmodule
